regfile_cycle_counter: RTL and testbench

Register file plus cycle counter for the pipelined 16-bit core. It holds the sixteen 16-bit architectural registers behind two synchronous read ports and one write port. It also counts clock cycles until the core asserts halt, and flags a timeout when a cycle budget is exhausted. It sits beside the pipeline: fetch-1 drives the read addresses, execute-0 consumes the read data, and write-back drives the write port.

---
 rtl/regfile_cycle_counter.sv | 115 +++++++++++
 tb/tb_regfile_cycle_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_cycle_counter.sv
// regfile_cycle_counter
//   Sixteen 16-bit architectural registers with two registered read ports and
//   one write port, plus a saturating cycle counter with a sticky timeout flag.
//   r0 reads as zero and ignores writes.
//
//   Build option: define REGFILE_BYPASS_EN for write-first reads. In that
//   build, a read that hits the address written in the same cycle returns
//   wdata. The default build is read-first and returns the old contents,
//   which the core's forwarding network relies on.
module regfile_cycle_counter #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       raddr0,
  output logic [15:0]      rdata0,
  input  logic [3:0]       raddr1,
  output logic [15:0]      rdata1,
  input  logic             wen,
  input  logic [3:0]       waddr,
  input  logic [15:0]      wdata,
  input  logic             halt,
  output logic [CNT_W-1:0] cycles,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // ---------------------------------------------------------------------------
  // Register storage and read ports
  // ---------------------------------------------------------------------------
  logic [15:0] mem_q [16];
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        wr_act;

  // A write to r0 is dropped here, so entry 0 never leaves its reset value.
  assign wr_act = wen && (waddr != 4'd0);

  // Select the next read data for each port. r0 is forced to zero. In the
  // bypass build, an in-cycle write is forwarded to the port.
  always_comb begin
    rdata0_d = mem_q[raddr0];
    rdata1_d = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_act && (waddr == raddr0)) rdata0_d = wdata;
    if (wr_act && (waddr == raddr1)) rdata1_d = wdata;
`endif
    if (raddr0 == 4'd0) rdata0_d = 16'h0000;
    if (raddr1 == 4'd0) rdata1_d = 16'h0000;
  end

  // Update the storage array. Reset clears every entry and overrides a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 16'h0000;
    end else if (wr_act) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Register both read ports. The array above still holds its old contents in
  // this cycle, which gives read-first behaviour in the default build.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
    end else begin
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

  // ---------------------------------------------------------------------------
  // Cycle counter and timeout
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic             cnt_en;

  // Count only while running. The count also stops at the top of its range,
  // so it can never wrap even when TIMEOUT exceeds what CNT_W can hold.
  assign cnt_en = !halt && !timeout_q && (cycles_q != CNT_MAX);

  // Compute the next count. Timeout sets on the increment that lands on the
  // budget, and both values then freeze until reset.
  always_comb begin
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    if (cnt_en) begin
      cycles_d = cycles_q + 1'b1;
      if (cycles_d == TIMEOUT_C) timeout_d = 1'b1;
    end
  end

  // Register the counter state. Reset overrides halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  assign cycles  = cycles_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_regfile_cycle_counter.sv
// Self-checking bench for regfile_cycle_counter (TIMEOUT=20).
// The reference model is an array of register values plus a counter.
// The counter is "non-halted cycles since reset, capped at TIMEOUT".
module tb_regfile_cycle_counter;
  localparam int TP = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  raddr0, raddr1, waddr;
  logic [15:0] rdata0, rdata1, wdata;
  logic        wen, halt;
  logic [31:0] cycles;
  logic        timeout;

  regfile_cycle_counter #(.TIMEOUT(TP), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .raddr0(raddr0), .rdata0(rdata0),
    .raddr1(raddr1), .rdata1(rdata1),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .halt(halt), .cycles(cycles), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Reference state.
  logic [15:0] m [16];
  int          cnt;
  logic [15:0] e_rd0, e_rd1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [3:0] a);
    if (reset) return 16'h0000;
    if (a == 4'd0) return 16'h0000;
    if (BYP && wen && waddr != 4'd0 && waddr == a) return wdata;
    return m[a];
  endfunction

  // Advance one edge with the current inputs, then update the model.
  task automatic tick();
    logic [15:0] n0, n1;
    n0 = rd_model(raddr0);
    n1 = rd_model(raddr1);
    if (reset) cnt = 0;
    else if (!halt && cnt < TP) cnt++;
    @(posedge clk); #1;
    if (reset) begin
      for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    end else if (wen && waddr != 4'd0) begin
      m[waddr] = wdata;
    end
    e_rd0 = n0;
    e_rd1 = n1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rdata0"}, 32'(rdata0), 32'(e_rd0));
    chk({tag, ".rdata1"}, 32'(rdata1), 32'(e_rd1));
    chk({tag, ".cycles"}, cycles, 32'(cnt));
    chk({tag, ".timeout"}, 32'(timeout), 32'(cnt >= TP));
  endtask

  initial begin
    cnt = 0;
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    reset = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    raddr0 = '0; raddr1 = '0; halt = 1'b0;

    // Reset state.
    tick();
    chk("rst.cycles", cycles, 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    chk("rst.rdata0", 32'(rdata0), 32'd0);
    reset = 1'b0;

    // Read r1..r15 on both ports after reset.
    for (int i = 1; i < 16; i++) begin
      raddr0 = 4'(i); raddr1 = 4'(16 - i);
      tick();
      if (i > 1) begin
        chk("rst_rd.r0", 32'(rdata0), 32'd0);
        chk("rst_rd.r1", 32'(rdata1), 32'd0);
      end
    end

    // Counter tests first, from a fresh reset.
    // Halt freeze: 10 run, 5 halted, 3 run.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    halt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("halt.hold", cycles, 32'd10);
    halt = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("halt.cycles", cycles, 32'd13);
    chk("halt.timeout", 32'(timeout), 32'd0);

    // Timeout at 20 edges, then hold.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 19) begin
        chk("to.c19", cycles, 32'd19);
        chk("to.t19", 32'(timeout), 32'd0);
      end
      if (k == 20) begin
        chk("to.c20", cycles, 32'd20);
        chk("to.t20", 32'(timeout), 32'd1);
      end
    end
    chk("to.c25", cycles, 32'd20);
    chk("to.t25", 32'(timeout), 32'd1);
    // Reset overrides halt.
    reset = 1'b1; halt = 1'b1; tick();
    chk("to.rst_c", cycles, 32'd0);
    chk("to.rst_t", 32'(timeout), 32'd0);
    reset = 1'b0; halt = 1'b0;

    // Write then read.
    wen = 1'b1; waddr = 4'd5; wdata = 16'hBEEF; tick();
    wen = 1'b0; raddr0 = 4'd5; tick();
    chk("wr.r5", 32'(rdata0), 32'h0000BEEF);
    wen = 1'b1; waddr = 4'd0; wdata = 16'h1234; tick();
    wen = 1'b0; raddr0 = 4'd0; tick();
    chk("wr.r0", 32'(rdata0), 32'h0);

    // Same-cycle collision on port 1.
    wen = 1'b1; waddr = 4'd3; wdata = 16'h0011; tick();
    wdata = 16'h00FF; raddr1 = 4'd3; tick();
    chk("coll.same", 32'(rdata1), BYP ? 32'h00FF : 32'h0011);
    wen = 1'b0; tick();
    chk("coll.next", 32'(rdata1), 32'h00FF);

    // Dual port reads.
    wen = 1'b1; waddr = 4'd7; wdata = 16'h8000; tick();
    waddr = 4'd8; wdata = 16'h0001; tick();
    wen = 1'b0; raddr0 = 4'd7; raddr1 = 4'd8; tick();
    chk("dual.r7", 32'(rdata0), 32'h8000);
    chk("dual.r8", 32'(rdata1), 32'h0001);
    raddr1 = 4'd7; tick();
    chk("dual.same0", 32'(rdata0), 32'h8000);
    chk("dual.same1", 32'(rdata1), 32'h8000);

    // Reset overrides a simultaneous write.
    reset = 1'b1; wen = 1'b1; waddr = 4'd9; wdata = 16'hA5A5; tick();
    reset = 1'b0; wen = 1'b0; raddr0 = 4'd9; raddr1 = 4'd7; tick();
    chk("rstwr.r9", 32'(rdata0), 32'h0);
    chk("rstwr.r7", 32'(rdata1), 32'h0);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 60) == 0);
      wen    = $urandom_range(0, 1) == 1;
      waddr  = 4'($urandom_range(0, 15));
      wdata  = 16'($urandom);
      raddr0 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      halt   = ($urandom_range(0, 3) == 0);
      tick();
      chk_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
